// File: rtl/divide_request_adapter_pkg.sv
// Shared encodings for the divide request adapter and the integer divider it fronts.
// Holds the op codes, the FSM states and the default widths.
package divide_request_adapter_pkg;

  localparam int DIV_OPERAND_WIDTH = 64;
  localparam int DIV_TAG_WIDTH     = 5;
  localparam int DIV_OP_WIDTH      = 2;

  typedef enum logic [DIV_OP_WIDTH-1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_RESP  = 3'd4
  } adapter_state_e;

  // Bit 0 of the op selects unsigned, bit 1 selects remainder.
  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/divide_request_adapter_twos_to_sign_magnitude.sv
// Splits a two's-complement operand into sign and magnitude; unsigned operands pass through.
// The most negative value maps to magnitude 2^(W-1), which fits the unsigned W-bit field.
module twos_to_sign_magnitude #(
  parameter int W = 64
) (
  input  logic [W-1:0] value,
  input  logic         is_signed,
  output logic         sign,
  output logic [W-1:0] magnitude
);

  assign sign      = is_signed & value[W-1];
  assign magnitude = sign ? -value : value;

endmodule

// File: rtl/divide_request_adapter.sv
// Adapts tagged DIV/DIVU/REM/REMU requests to the sign-magnitude integer divider,
// resolving divide-by-zero and signed overflow locally without touching the divider.
module divide_request_adapter
  import divide_request_adapter_pkg::*;
#(
  parameter int OPERAND_WIDTH_IN_BITS = DIV_OPERAND_WIDTH,
  parameter int TAG_WIDTH             = DIV_TAG_WIDTH
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             req_valid_in,
  output logic                             req_ready_out,
  input  logic [1:0]                       req_op_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] req_dividend_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] req_divisor_in,
  input  logic [TAG_WIDTH-1:0]             req_tag_in,
  output logic                             div_valid_out,
  output logic                             div_dividend_sign_out,
  output logic                             div_divisor_sign_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] div_dividend_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] div_divisor_out,
  input  logic                             div_issue_ack_in,
  input  logic                             div_valid_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] div_quotient_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] div_remainder_in,
  input  logic                             div_quotient_sign_in,
  input  logic                             div_remainder_sign_in,
  input  logic                             div_divide_by_zero_in,
  output logic                             div_issue_ack_out,
  output logic                             resp_valid_out,
  input  logic                             resp_ready_in,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] resp_data_out,
  output logic [TAG_WIDTH-1:0]             resp_tag_out
);

  localparam int W = OPERAND_WIDTH_IN_BITS;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  adapter_state_e state, state_nxt;

  div_op_e              op_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 dividend_sign_q, divisor_sign_q;
  logic [W-1:0]         dividend_mag_q, divisor_mag_q;
  logic [W-1:0]         result_q;

  div_op_e      req_op;
  logic         req_signed, req_rem;
  logic         dividend_sign, divisor_sign;
  logic [W-1:0] dividend_mag, divisor_mag;
  logic         divisor_zero, signed_overflow, bypass;
  logic [W-1:0] bypass_result;
  logic [W-1:0] quotient_fixed, remainder_fixed;
  logic         accept, capture;

  // The divider's own sign and zero flags are redundant with the locally latched signs.
  logic unused_div_flags;
  assign unused_div_flags = ^{div_quotient_sign_in, div_remainder_sign_in, div_divide_by_zero_in};

  assign req_op     = div_op_e'(req_op_in);
  assign req_signed = op_is_signed(req_op);
  assign req_rem    = op_is_rem(req_op);

  twos_to_sign_magnitude #(.W(W)) u_dividend_sm (
    .value     (req_dividend_in),
    .is_signed (req_signed),
    .sign      (dividend_sign),
    .magnitude (dividend_mag)
  );

  twos_to_sign_magnitude #(.W(W)) u_divisor_sm (
    .value     (req_divisor_in),
    .is_signed (req_signed),
    .sign      (divisor_sign),
    .magnitude (divisor_mag)
  );

  assign divisor_zero    = (req_divisor_in == '0);
  assign signed_overflow = req_signed && (req_dividend_in == MIN_VAL) && (req_divisor_in == '1);
  assign bypass          = divisor_zero | signed_overflow;

  always_comb begin
    bypass_result = '0;
    if (divisor_zero)
      bypass_result = req_rem ? req_dividend_in : '1;
    else if (signed_overflow)
      bypass_result = req_rem ? '0 : MIN_VAL;
  end

  assign quotient_fixed  = (dividend_sign_q ^ divisor_sign_q) ? -div_quotient_in : div_quotient_in;
  assign remainder_fixed = dividend_sign_q ? -div_remainder_in : div_remainder_in;

  assign accept  = (state == ST_IDLE) && req_valid_in;
  assign capture = (state == ST_WAIT) && div_valid_in;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    req_ready_out     = 1'b0;
    div_valid_out     = 1'b0;
    div_issue_ack_out = 1'b0;
    resp_valid_out    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) state_nxt = bypass ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        div_valid_out = 1'b1;
        if (div_issue_ack_in) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_valid_in) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        div_issue_ack_out = 1'b1;
        state_nxt         = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_out = 1'b1;
        if (resp_ready_in) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      op_q            <= OP_DIV;
      tag_q           <= '0;
      dividend_sign_q <= 1'b0;
      divisor_sign_q  <= 1'b0;
      dividend_mag_q  <= '0;
      divisor_mag_q   <= '0;
      result_q        <= '0;
    end else begin
      if (accept) begin
        op_q            <= req_op;
        tag_q           <= req_tag_in;
        dividend_sign_q <= dividend_sign;
        divisor_sign_q  <= divisor_sign;
        dividend_mag_q  <= dividend_mag;
        divisor_mag_q   <= divisor_mag;
        result_q        <= bypass_result;
      end
      if (capture)
        result_q <= op_is_rem(op_q) ? remainder_fixed : quotient_fixed;
    end
  end

  assign div_dividend_sign_out = dividend_sign_q;
  assign div_divisor_sign_out  = divisor_sign_q;
  assign div_dividend_out      = dividend_mag_q;
  assign div_divisor_out       = divisor_mag_q;
  assign resp_data_out         = result_q;
  assign resp_tag_out          = tag_q;

endmodule

// File: tb/tb_divide_request_adapter.sv
// Directed bench for divide_request_adapter at W=64; the bench plays the divider with
// fixed-latency handshakes and compares against hand-computed results.
module tb_divide_request_adapter;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [1:0]  req_op_in;
  logic [63:0] req_dividend_in, req_divisor_in;
  logic [4:0]  req_tag_in;
  logic        div_valid_out, div_dividend_sign_out, div_divisor_sign_out;
  logic [63:0] div_dividend_out, div_divisor_out;
  logic        div_issue_ack_in, div_valid_in;
  logic [63:0] div_quotient_in, div_remainder_in;
  logic        div_quotient_sign_in, div_remainder_sign_in, div_divide_by_zero_in;
  logic        div_issue_ack_out;
  logic        resp_valid_out, resp_ready_in;
  logic [63:0] resp_data_out;
  logic [4:0]  resp_tag_out;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int dv_cnt = 0;

  always #5 clk_in = ~clk_in;

  divide_request_adapter #(.OPERAND_WIDTH_IN_BITS(64), .TAG_WIDTH(5)) dut (
    .clk_in                (clk_in),
    .reset_in              (reset_in),
    .req_valid_in          (req_valid_in),
    .req_ready_out         (req_ready_out),
    .req_op_in             (req_op_in),
    .req_dividend_in       (req_dividend_in),
    .req_divisor_in        (req_divisor_in),
    .req_tag_in            (req_tag_in),
    .div_valid_out         (div_valid_out),
    .div_dividend_sign_out (div_dividend_sign_out),
    .div_divisor_sign_out  (div_divisor_sign_out),
    .div_dividend_out      (div_dividend_out),
    .div_divisor_out       (div_divisor_out),
    .div_issue_ack_in      (div_issue_ack_in),
    .div_valid_in          (div_valid_in),
    .div_quotient_in       (div_quotient_in),
    .div_remainder_in      (div_remainder_in),
    .div_quotient_sign_in  (div_quotient_sign_in),
    .div_remainder_sign_in (div_remainder_sign_in),
    .div_divide_by_zero_in (div_divide_by_zero_in),
    .div_issue_ack_out     (div_issue_ack_out),
    .resp_valid_out        (resp_valid_out),
    .resp_ready_in         (resp_ready_in),
    .resp_data_out         (resp_data_out),
    .resp_tag_out          (resp_tag_out)
  );

  always @(posedge clk_in) begin
    if (div_issue_ack_out) ack_cnt <= ack_cnt + 1;
    if (div_valid_out)     dv_cnt  <= dv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with the adapter idle; ends at a negedge with it idle again.
  task automatic run_req(input string nm, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tg, input bit byp,
                         input logic as, input logic [63:0] am, input logic bs,
                         input logic [63:0] bm, input logic [63:0] expd, input int hold);
    int acks0, dvs0;
    acks0 = ack_cnt;
    dvs0  = dv_cnt;
    chk({nm, " idle_rdy"}, req_ready_out, 1);
    req_valid_in = 1'b1; req_op_in = op; req_dividend_in = a; req_divisor_in = b; req_tag_in = tg;
    @(negedge clk_in);
    req_valid_in = 1'b0; req_dividend_in = ~a; req_divisor_in = ~b; req_tag_in = ~tg;
    chk({nm, " busy_rdy"}, req_ready_out, 0);
    if (!byp) begin
      chk({nm, " issue_dv"}, div_valid_out, 1);
      chk({nm, " a_sign"}, div_dividend_sign_out, as);
      chk({nm, " a_mag"}, div_dividend_out, am);
      chk({nm, " b_sign"}, div_divisor_sign_out, bs);
      chk({nm, " b_mag"}, div_divisor_out, bm);
      // A result outside WAIT must not be taken.
      div_valid_in = 1'b1; div_quotient_in = '1; div_remainder_in = '1;
      @(negedge clk_in);
      div_valid_in = 1'b0;
      chk({nm, " hold_dv"}, div_valid_out, 1);
      chk({nm, " hold_a"}, div_dividend_out, am);
      div_issue_ack_in = 1'b1;
      @(negedge clk_in);
      div_issue_ack_in = 1'b0;
      chk({nm, " wait_dv"}, div_valid_out, 0);
      @(negedge clk_in);
      div_valid_in = 1'b1; div_quotient_in = am / bm; div_remainder_in = am % bm;
      div_quotient_sign_in = 1'b1; div_remainder_sign_in = 1'b1; div_divide_by_zero_in = 1'b1;
      @(negedge clk_in);
      div_valid_in = 1'b0; div_quotient_sign_in = 1'b0; div_remainder_sign_in = 1'b0;
      div_divide_by_zero_in = 1'b0;
      chk({nm, " ack_pulse"}, div_issue_ack_out, 1);
      chk({nm, " ack_rv"}, resp_valid_out, 0);
      @(negedge clk_in);
      chk({nm, " ack_drop"}, div_issue_ack_out, 0);
    end
    chk({nm, " rv"}, resp_valid_out, 1);
    chk({nm, " data"}, resp_data_out, expd);
    chk({nm, " tag"}, resp_tag_out, tg);
    chk({nm, " resp_dv"}, div_valid_out, 0);
    for (int i = 0; i < hold; i++) begin
      div_issue_ack_in = 1'b1;
      @(negedge clk_in);
      div_issue_ack_in = 1'b0;
      chk({nm, " stall_rv"}, resp_valid_out, 1);
      chk({nm, " stall_data"}, resp_data_out, expd);
      chk({nm, " stall_tag"}, resp_tag_out, tg);
      chk({nm, " stall_rdy"}, req_ready_out, 0);
    end
    resp_ready_in = 1'b1;
    @(negedge clk_in);
    resp_ready_in = 1'b0;
    chk({nm, " done_rv"}, resp_valid_out, 0);
    chk({nm, " done_rdy"}, req_ready_out, 1);
    chk({nm, " ack_count"}, ack_cnt - acks0, byp ? 0 : 1);
    if (byp) chk({nm, " dv_count"}, dv_cnt - dvs0, 0);
  endtask

  initial begin
    reset_in = 1'b0; req_valid_in = 1'b0; req_op_in = 2'b00; req_dividend_in = '0;
    req_divisor_in = '0; req_tag_in = '0; div_issue_ack_in = 1'b0; div_valid_in = 1'b0;
    div_quotient_in = '0; div_remainder_in = '0; div_quotient_sign_in = 1'b0;
    div_remainder_sign_in = 1'b0; div_divide_by_zero_in = 1'b0; resp_ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst dv", div_valid_out, 0);
    chk("rst rv", resp_valid_out, 0);
    chk("rst ack", div_issue_ack_out, 0);
    chk("rst data", resp_data_out, 0);
    chk("rst tag", resp_tag_out, 0);
    chk("rst a_mag", div_dividend_out, 0);
    reset_in = 1'b1;
    @(negedge clk_in);
    chk("rst rdy", req_ready_out, 1);

    //      name        op     dividend               divisor                tag    byp as a_mag                  bs b_mag                  expected               hold
    run_req("div-7/2",  2'b00, 64'hFFFFFFFFFFFFFFF9, 64'd2,                5'h03, 0, 1, 64'd7,                 0, 64'd2,                 64'hFFFFFFFFFFFFFFFD, 0);
    run_req("rem-7/2",  2'b10, 64'hFFFFFFFFFFFFFFF9, 64'd2,                5'h04, 0, 1, 64'd7,                 0, 64'd2,                 64'hFFFFFFFFFFFFFFFF, 0);
    run_req("divu100",  2'b01, 64'd100,              64'd7,                5'h15, 0, 0, 64'd100,               0, 64'd7,                 64'd14,               3);
    run_req("remu100",  2'b11, 64'd100,              64'd7,                5'h15, 0, 0, 64'd100,               0, 64'd7,                 64'd2,                0);
    run_req("div5/0",   2'b00, 64'd5,                64'd0,                5'h01, 1, 0, 64'd0,                 0, 64'd0,                 64'hFFFFFFFFFFFFFFFF, 0);
    run_req("rem5/0",   2'b10, 64'd5,                64'd0,                5'h02, 1, 0, 64'd0,                 0, 64'd0,                 64'd5,                3);
    run_req("remu-7/0", 2'b11, 64'hFFFFFFFFFFFFFFF9, 64'd0,                5'h1F, 1, 0, 64'd0,                 0, 64'd0,                 64'hFFFFFFFFFFFFFFF9, 0);
    run_req("div_ovf",  2'b00, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'h0A, 1, 0, 64'd0,                 0, 64'd0,                 64'h8000000000000000, 0);
    run_req("rem_ovf",  2'b10, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'h0B, 1, 0, 64'd0,                 0, 64'd0,                 64'd0,                0);
    run_req("divu_min", 2'b01, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'h0C, 0, 0, 64'h8000000000000000, 0, 64'hFFFFFFFFFFFFFFFF, 64'd0,                0);
    run_req("div7/-2",  2'b00, 64'd7,                64'hFFFFFFFFFFFFFFFE, 5'h0D, 0, 0, 64'd7,                 1, 64'd2,                 64'hFFFFFFFFFFFFFFFD, 0);
    run_req("rem7/-2",  2'b10, 64'd7,                64'hFFFFFFFFFFFFFFFE, 5'h0E, 0, 0, 64'd7,                 1, 64'd2,                 64'd1,                0);
    run_req("divmin/2", 2'b00, 64'h8000000000000000, 64'd2,                5'h0F, 0, 1, 64'h8000000000000000, 0, 64'd2,                 64'hC000000000000000, 0);

    // Reset while the divider is being offered operands.
    req_valid_in = 1'b1; req_op_in = 2'b00; req_dividend_in = 64'd9; req_divisor_in = 64'd3;
    req_tag_in = 5'h07;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    chk("abort issue_dv", div_valid_out, 1);
    #3 reset_in = 1'b0;
    #1;
    chk("abort dv_now", div_valid_out, 0);
    chk("abort rv_now", resp_valid_out, 0);
    @(negedge clk_in);
    reset_in = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      chk("abort rv", resp_valid_out, 0);
      chk("abort dv", div_valid_out, 0);
    end
    run_req("after_rst", 2'b01, 64'd42, 64'd5, 5'h11, 0, 0, 64'd42, 0, 64'd5, 64'd8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
